// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable UART tick generator.
// A prescaler divides clk by the active divisor D to give ovs_tick. An
// oversample counter divides that by OVS to give half_bit_tick and bit_tick.
// New divisors wait in a shadow register and are applied only on a bit
// boundary, on restart, or while idle, so a bit is never truncated.
// Optional feature macro: BAUD_GEN_FRAC_EN adds the div_frac port and a
// 4-bit fractional accumulator that stretches some periods to D+1 cycles.
module baud_tick_gen #(
  parameter int CNT_W       = 16,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
`ifdef BAUD_GEN_FRAC_EN
  input  logic [3:0]       div_frac,
`endif
  output logic             div_pending,
  output logic             div_err,
  output logic             ovs_tick,
  output logic             half_bit_tick,
  output logic             bit_tick
);

  localparam int OCNT_W = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [OCNT_W-1:0] OCNT_HALF = OCNT_W'(OVS / 2 - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic [CNT_W-1:0]  div_act_q, div_act_d;
  logic [CNT_W-1:0]  div_shd_q, div_shd_d;
  logic              div_pending_q, div_pending_d;
  logic              div_err_q, div_err_d;
  logic [CNT_W-1:0]  pcnt_term;
  logic              ovs_hit, load_ok, apply;

`ifdef BAUD_GEN_FRAC_EN
  logic [3:0] frac_act_q, frac_act_d;
  logic [3:0] frac_shd_q, frac_shd_d;
  logic [3:0] acc_q, acc_d;
  logic       ext_q, ext_d;

  // A carry out of the accumulator stretches the following period by one cycle.
  always_comb begin
    pcnt_term = ext_q ? div_act_q : (div_act_q - CNT_W'(1));
  end
`else
  // Terminal count of the prescaler for an exact D-cycle period.
  always_comb begin
    pcnt_term = div_act_q - CNT_W'(1);
  end
`endif

  // Tick decode straight from registers; restart and reset suppress ticks.
  always_comb begin
    ovs_hit       = enable && !restart && !rst && (pcnt_q == pcnt_term);
    ovs_tick      = ovs_hit;
    half_bit_tick = ovs_hit && (ocnt_q == OCNT_HALF);
    bit_tick      = ovs_hit && (ocnt_q == OCNT_LAST);
    load_ok       = div_load && (div_value != '0);
    apply         = bit_tick || restart ||
                    (!enable && (pcnt_q == '0) && (ocnt_q == '0));
  end

  // Next-state for counters and divisor shadowing.
  always_comb begin
    pcnt_d        = pcnt_q;
    ocnt_d        = ocnt_q;
    div_act_d     = apply ? div_shd_q : div_act_q;
    div_shd_d     = load_ok ? div_value : div_shd_q;
    div_pending_d = load_ok ? 1'b1 : (apply ? 1'b0 : div_pending_q);
    div_err_d     = div_load && (div_value == '0);
    if (restart) begin
      pcnt_d = '0;
      ocnt_d = '0;
    end else if (enable) begin
      pcnt_d = ovs_hit ? '0 : (pcnt_q + CNT_W'(1));
      if (ovs_hit) begin
        ocnt_d = bit_tick ? '0 : (ocnt_q + OCNT_W'(1));
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  // Fractional part travels with the integer divisor; accumulate on each tick.
  always_comb begin
    frac_shd_d = load_ok ? div_frac : frac_shd_q;
    frac_act_d = apply ? frac_shd_q : frac_act_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    if (restart) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (ovs_hit) begin
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_act_q};
    end
  end

  // Fractional state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_act_q <= '0;
      frac_shd_q <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
    end else begin
      frac_act_q <= frac_act_d;
      frac_shd_q <= frac_shd_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
    end
  end
`endif

  // Main state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q        <= '0;
      ocnt_q        <= '0;
      div_act_q     <= DIV_RST;
      div_shd_q     <= DIV_RST;
      div_pending_q <= 1'b0;
      div_err_q     <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      ocnt_q        <= ocnt_d;
      div_act_q     <= div_act_d;
      div_shd_q     <= div_shd_d;
      div_pending_q <= div_pending_d;
      div_err_q     <= div_err_d;
    end
  end

  assign div_pending = div_pending_q;
  assign div_err     = div_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: a vector table for the default divisor
// run and a mid-run divisor load, then hand sequences for zero loads,
// restart, async reset, the D=1/OVS=2 corner and (if built with
// BAUD_GEN_FRAC_EN) fractional periods.
module tb_baud_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, restart = 1'b0, div_load = 1'b0;
  logic [15:0] div_value = '0;
  logic enable1 = 1'b0, restart1 = 1'b0, div_load1 = 1'b0;
  logic [15:0] div_value1 = '0;
  logic pend0, err0, ovs0, half0, bit0;
  logic pend1, err1, ovs1, half1, bit1;
`ifdef BAUD_GEN_FRAC_EN
  logic [3:0] div_frac = '0;
  logic [3:0] div_frac1 = '0;
`endif

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(.CNT_W(16), .OVS(16), .DEFAULT_DIV(54)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .div_load(div_load), .div_value(div_value),
`ifdef BAUD_GEN_FRAC_EN
    .div_frac(div_frac),
`endif
    .div_pending(pend0), .div_err(err0), .ovs_tick(ovs0),
    .half_bit_tick(half0), .bit_tick(bit0)
  );

  baud_tick_gen #(.CNT_W(16), .OVS(2), .DEFAULT_DIV(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable1), .restart(restart1),
    .div_load(div_load1), .div_value(div_value1),
`ifdef BAUD_GEN_FRAC_EN
    .div_frac(div_frac1),
`endif
    .div_pending(pend1), .div_err(err1), .ovs_tick(ovs1),
    .half_bit_tick(half1), .bit_tick(bit1)
  );

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] val;
    logic        ovs;
    logic        half;
    logic        bt;
    logic        pend;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  // One clock: inputs change 1 time unit after the edge, pulses auto-clear.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    div_load = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic adv_to(input int c);
    while (cyc < c) step();
    #1;
  endtask

  initial begin
    int n;
    int ovs_at[3];
    int k;

    vt = '{
      '{1,    1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{53,   1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{54,   1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0},
      '{55,   1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{100,  1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0},
      '{101,  1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1},
      '{108,  1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1},
      '{432,  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b1},
      '{863,  1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1},
      '{864,  1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b1},
      '{865,  1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{873,  1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{874,  1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0},
      '{944,  1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0},
      '{1024, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0},
      '{1034, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0}
    };

    // Reset state, with both instances enabled so tick gating is exercised.
    enable  = 1'b1;
    enable1 = 1'b1;
    #3;
    chk("rst_pend", int'(pend0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_ovs", int'(ovs0), 0);
    chk("rst_bit", int'(bit0), 0);
    chk("rst_ovs_d1", int'(ovs1), 0);
    enable1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;

    // Default D=54 run with a load of D=10 at cycle 100.
    for (int i = 0; i < 16; i++) begin
      while (cyc < vt[i].cyc) step();
      div_load  = vt[i].ld;
      div_value = vt[i].val;
      #1;
      chk($sformatf("vec%0d_ovs", i), int'(ovs0), int'(vt[i].ovs));
      chk($sformatf("vec%0d_half", i), int'(half0), int'(vt[i].half));
      chk($sformatf("vec%0d_bit", i), int'(bit0), int'(vt[i].bt));
      chk($sformatf("vec%0d_pend", i), int'(pend0), int'(vt[i].pend));
    end

    // Zero divisor load: error pulse, divisor and pending untouched.
    adv_to(1035);
    div_load = 1'b1;
    div_value = 16'd0;
    adv_to(1036);
    chk("err_pulse", int'(err0), 1);
    chk("err_pend", int'(pend0), 0);
    adv_to(1037);
    chk("err_clear", int'(err0), 0);
    adv_to(1043);
    chk("err_d_kept_pre", int'(ovs0), 0);
    adv_to(1044);
    chk("err_d_kept", int'(ovs0), 1);

    // Restart mid-bit with D=5 pending; restart lands on a would-be tick.
    adv_to(1046);
    div_load = 1'b1;
    div_value = 16'd5;
    adv_to(1047);
    chk("rs_pend_set", int'(pend0), 1);
    adv_to(1054);
    restart = 1'b1;
    #1;
    chk("rs_no_tick", int'(ovs0), 0);
    adv_to(1055);
    chk("rs_pend_clr", int'(pend0), 0);
    adv_to(1058);
    chk("rs_ovs_pre", int'(ovs0), 0);
    adv_to(1059);
    chk("rs_ovs_d5", int'(ovs0), 1);
    adv_to(1094);
    chk("rs_half", int'(half0), 1);
    adv_to(1134);
    chk("rs_bit", int'(bit0), 1);

    // Async reset mid-bit with D=7 pending: outputs drop at once, D=7 lost.
    adv_to(1140);
    div_load = 1'b1;
    div_value = 16'd7;
    adv_to(1141);
    chk("ar_pend_set", int'(pend0), 1);
    adv_to(1144);
    chk("ar_ovs_before", int'(ovs0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ovs", int'(ovs0), 0);
    chk("ar_pend", int'(pend0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    #1;
    chk("ar_pend_after", int'(pend0), 0);
    adv_to(7);
    chk("ar_no_d7", int'(ovs0), 0);
    adv_to(54);
    chk("ar_d54", int'(ovs0), 1);

    // D=1, OVS=2: tick every cycle, bit every second cycle, freeze on enable low.
    enable1 = 1'b1;
    #1;
    chk("d1_c1_ovs", int'(ovs1), 1);
    chk("d1_c1_half", int'(half1), 1);
    chk("d1_c1_bit", int'(bit1), 0);
    adv_to(cyc + 1);
    chk("d1_c2_ovs", int'(ovs1), 1);
    chk("d1_c2_bit", int'(bit1), 1);
    adv_to(cyc + 1);
    chk("d1_c3_bit", int'(bit1), 0);
    chk("d1_c3_half", int'(half1), 1);
    adv_to(cyc + 1);
    enable1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("d1_hold_ovs", int'(ovs1), 0);
      chk("d1_hold_bit", int'(bit1), 0);
      adv_to(cyc + 1);
    end
    enable1 = 1'b1;
    #1;
    chk("d1_resume_bit", int'(bit1), 1);

`ifdef BAUD_GEN_FRAC_EN
    // D=54 + 8/16: periods 54,54,55,...; the first bit after restart has 7
    // stretched periods (871), every later bit has 8 (872).
    adv_to(cyc + 1);
    div_load  = 1'b1;
    div_value = 16'd54;
    div_frac  = 4'd8;
    adv_to(cyc + 1);
    restart = 1'b1;
    adv_to(cyc + 1);
    n = 1;
    k = 0;
    while (!bit0 && n < 2000) begin
      if (ovs0 && k < 3) begin
        ovs_at[k] = n;
        k++;
      end
      adv_to(cyc + 1);
      n++;
    end
    chk("fr_ovs1", ovs_at[0], 54);
    chk("fr_ovs2", ovs_at[1], 108);
    chk("fr_ovs3", ovs_at[2], 163);
    chk("fr_bit1_len", n, 871);
    adv_to(cyc + 1);
    n = 1;
    while (!bit0 && n < 2000) begin
      adv_to(cyc + 1);
      n++;
    end
    chk("fr_bit2_len", n, 872);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable tick generator for the UART datapath; replaces the fixed-count delay counter with a runtime-loadable divisor and an oversampling stage. Produces an oversample tick, a mid-bit tick for RX centre sampling and an end-of-bit tick for TX/RX bit advance. Divisor updates are shadowed and applied only on bit boundaries, so baud changes never produce a truncated bit.

## Interface
- `CNT_W`, 16, width of prescaler counter and divisor.
- `OVS`, 16, oversample ticks per bit; even, ≥ 2.
- `DEFAULT_DIV`, 54, active divisor after reset; 1 ≤ value < 2^CNT_W.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: counters advance only while high; hold state when low.
- `restart` in 1: synchronous clear of both counters; applies any pending divisor.
- `div_load` in 1: one-cycle request to load `div_value`.
- `div_value` in CNT_W: new divisor D; 0 is illegal.
- `div_frac` in 4: fractional divisor part in 1/16ths (only with `BAUD_GEN_FRAC_EN`).
- `div_pending` out 1: shadow holds a divisor not yet applied.
- `div_err` out 1: one-cycle pulse, `div_load` with `div_value` = 0.
- `ovs_tick` out 1: one-cycle pulse every D enabled cycles.
- `half_bit_tick` out 1: one-cycle pulse at the middle of each bit.
- `bit_tick` out 1: one-cycle pulse at the end of each bit.

## Operation
- Registers: prescaler `pcnt` (CNT_W), oversample counter `ocnt` (clog2(OVS)), active divisor `div_act`, shadow `div_shd`, `div_pending`.
- Reset: `pcnt`=0, `ocnt`=0, `div_act`=DEFAULT_DIV, `div_shd`=DEFAULT_DIV, `div_pending`=0, `div_err`=0; all ticks 0.
- `ovs_tick` = `enable` & (`pcnt` == `div_act`−1); decoded from registers, same-cycle.
- `half_bit_tick` = `ovs_tick` & (`ocnt` == OVS/2−1); `bit_tick` = `ovs_tick` & (`ocnt` == OVS−1).
- While `enable`: `pcnt` increments, wraps to 0 on `ovs_tick`; `ocnt` increments on `ovs_tick`, wraps to 0 on `bit_tick`.
- `enable` low: counters hold, no ticks.
- `div_load` with nonzero `div_value`: `div_shd` ← `div_value`, `div_pending` ← 1. Zero value: shadow unchanged, `div_err` pulses next cycle.
- Apply: `div_act` ← `div_shd`, `div_pending` ← 0 on `bit_tick`, on `restart`, or in any cycle with `enable` low and `pcnt`=`ocnt`=0.
- Simultaneous `div_load` and apply: the value being applied is the old shadow; the new value is captured into the shadow and `div_pending` stays 1.
- `restart` has priority over `enable`: counters ← 0, no tick that cycle.
- D = 1: `ovs_tick` high every enabled cycle.

## Timing
- From `restart` deasserted with `enable` held high, counting the first enabled cycle as 1: `ovs_tick` in cycles D, 2D, …; `half_bit_tick` in cycle D·OVS/2; `bit_tick` in cycle D·OVS.
- Bit period D·OVS cycles exactly (integer mode).
- `div_pending` rises the cycle after `div_load`; new divisor governs the first bit after the next `bit_tick`.
- Reset is asynchronous mid-operation: all state returns to reset values immediately, and any pending divisor is lost.

## Configuration
- `BAUD_GEN_FRAC_EN` defined: the `div_frac` port exists and is shadowed and applied together with `div_value`. A 4-bit accumulator adds `div_frac` on each `ovs_tick`. When the add carries, the next oversample period is D+1 cycles, so the average period is D + frac/16. The accumulator clears on reset and `restart`.
- Not defined: no `div_frac` port and no accumulator; every period is exactly D.

## Test plan
- Reset, `enable`=1, DEFAULT_DIV=54, OVS=16 -> `ovs_tick` every 54 cycles, `half_bit_tick` at cycle 432, `bit_tick` at cycle 864, repeating.
- Load D=10 at cycle 100 of a D=54 bit -> `div_pending`=1 until the `bit_tick` at cycle 864; the following bit lasts 160 cycles and `div_pending` then reads 0.
- `div_load` with `div_value`=0 -> `div_err` pulses once; `div_act` and `div_pending` unchanged.
- D=1, OVS=2 -> `ovs_tick` constant high, `bit_tick` every 2nd cycle; `enable` low for 5 cycles -> no ticks and counters frozen.
- `restart` mid-bit with a load pending -> counters clear and the new D takes effect immediately; async `rst` mid-bit -> all outputs 0 in the same cycle.
- `BAUD_GEN_FRAC_EN`, D=54, `div_frac`=8 -> periods alternate 54/55, and one bit takes 872 cycles.
